// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU execute path: op encodings and operand-A select values.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NE   = 4'd11
  } alu_pipe_op_t;

  localparam logic S1_SRC1 = 1'b0;
  localparam logic S1_PC   = 1'b1;

  // Register index type shared with the rest of the core's register-file plumbing.
  localparam int REG_IDX_W = 5;
  typedef logic [REG_IDX_W-1:0] reg_t;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU evaluation for the execute pipe; undefined op encodings produce zero.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    // NOTE: a default ahead of the case keeps every path assigned, so no latch is inferred.
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
      ALU_EQ:   result = {{(XLEN-1){1'b0}}, a == b};
      ALU_NE:   result = {{(XLEN-1){1'b0}}, a != b};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_pipe.sv
// Pipelined ALU execute path with valid/ready handshake, bubble collapse and flush.
// Optional performance counters are built only when ALU_PIPE_PERF_EN is defined.
module alu_exec_pipe
  import alu_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic             in_s1_sel,
  input  logic [XLEN-1:0]  in_src_1,
  input  logic [XLEN-1:0]  in_src_2,
  input  logic [XLEN-1:0]  in_src_3,
  input  logic             in_wb_wr,
  input  logic [REG_W-1:0] in_reg_dst,
  input  logic             in_pc_branch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_dst,
  output logic             out_wb_wr,
  output logic [REG_W-1:0] out_reg_dst,
  output logic             out_pc_branch,
  output logic [CNT_W-1:0] perf_accept,
  output logic [CNT_W-1:0] perf_stall
);

  typedef struct packed {
    logic [XLEN-1:0]  dst;
    logic             wb_wr;
    logic [REG_W-1:0] reg_dst;
    logic             pc_branch;
  } stage_t;

  logic [STAGES-1:0] valid;
  stage_t            stage_q [STAGES];
  logic [STAGES-1:0] en;
  stage_t            stage_in;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   alu_res;

  assign op_a = (in_s1_sel == S1_PC) ? in_src_3 : in_src_1;

  alu_pipe_core #(.XLEN(XLEN)) u_core (
    .op     (in_op),
    .a      (op_a),
    .b      (in_src_2),
    .result (alu_res)
  );

  // Writes to x0 are dropped here so writeback never sees them.
  always_comb begin
    stage_in.dst       = alu_res;
    stage_in.wb_wr     = in_wb_wr && (in_reg_dst != '0);
    stage_in.reg_dst   = in_reg_dst;
    stage_in.pc_branch = in_pc_branch;
  end

  // Ready chain from the writeback side back to stage 0; an empty stage always accepts.
  always_comb begin
    logic acc;
    acc = out_ready;
    en  = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc   = !valid[i] || acc;
      en[i] = acc;
    end
  end

  assign in_ready = en[0] && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      // NOTE: the stage array is a handful of flops, not a RAM, so resetting it is cheap and keeps outputs at zero.
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else if (flush) begin
      valid <= '0;
    end else begin
      // NOTE: non-blocking updates let every stage sample its predecessor's pre-edge value.
      if (en[0]) begin
        valid[0] <= in_valid;
        if (in_valid) stage_q[0] <= stage_in;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (en[i]) begin
          valid[i] <= valid[i-1];
          if (valid[i-1]) stage_q[i] <= stage_q[i-1];
        end
      end
    end
  end

  assign out_valid     = valid[STAGES-1];
  assign out_dst       = stage_q[STAGES-1].dst;
  assign out_wb_wr     = stage_q[STAGES-1].wb_wr;
  assign out_reg_dst   = stage_q[STAGES-1].reg_dst;
  assign out_pc_branch = stage_q[STAGES-1].pc_branch;

`ifdef ALU_PIPE_PERF_EN
  logic [CNT_W-1:0] accept_q;
  logic [CNT_W-1:0] stall_q;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_q <= '0;
      stall_q  <= '0;
    end else begin
      if (in_valid && in_ready && (accept_q != '1)) accept_q <= accept_q + CNT_W'(1);
      if (out_valid && !out_ready && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign perf_accept = accept_q;
  assign perf_stall  = stall_q;
`else
  assign perf_accept = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed bench for alu_exec_pipe (XLEN=32, STAGES=2, CNT_W=4); perf expectations follow ALU_PIPE_PERF_EN.
module tb_alu_exec_pipe;
  import alu_pipe_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic        in_s1_sel;
  logic [31:0] in_src_1;
  logic [31:0] in_src_2;
  logic [31:0] in_src_3;
  logic        in_wb_wr;
  logic [4:0]  in_reg_dst;
  logic        in_pc_branch;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_dst;
  logic        out_wb_wr;
  logic [4:0]  out_reg_dst;
  logic        out_pc_branch;
  logic [3:0]  perf_accept;
  logic [3:0]  perf_stall;

  int checks = 0;
  int errors = 0;

  alu_exec_pipe #(.XLEN(32), .STAGES(2), .REG_W(5), .CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_s1_sel     (in_s1_sel),
    .in_src_1      (in_src_1),
    .in_src_2      (in_src_2),
    .in_src_3      (in_src_3),
    .in_wb_wr      (in_wb_wr),
    .in_reg_dst    (in_reg_dst),
    .in_pc_branch  (in_pc_branch),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_dst       (out_dst),
    .out_wb_wr     (out_wb_wr),
    .out_reg_dst   (out_reg_dst),
    .out_pc_branch (out_pc_branch),
    .perf_accept   (perf_accept),
    .perf_stall    (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pexp(input int v);
`ifdef ALU_PIPE_PERF_EN
    return 64'(v);
`else
    return 64'(v * 0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] op, input logic sel, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] s3, input logic wb,
                         input logic [4:0] dst, input logic br);
    in_valid     = 1'b1;
    in_op        = op;
    in_s1_sel    = sel;
    in_src_1     = s1;
    in_src_2     = s2;
    in_src_3     = s3;
    in_wb_wr     = wb;
    in_reg_dst   = dst;
    in_pc_branch = br;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Single op with out_ready held high: result must appear exactly two edges after accept.
  task automatic run_op(input string tag, input logic [3:0] op, input logic sel,
                        input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] s3,
                        input logic wb, input logic [4:0] dst, input logic br,
                        input logic [31:0] exp_dst, input logic exp_wb);
    set_req(op, sel, s1, s2, s3, wb, dst, br);
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    tick();
    idle();
    @(negedge clk);
    check({tag, ".lat1_valid"}, 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".out_dst"}, 64'(out_dst), 64'(exp_dst));
    check({tag, ".out_wb_wr"}, 64'(out_wb_wr), 64'(exp_wb));
    check({tag, ".out_reg_dst"}, 64'(out_reg_dst), 64'(dst));
    check({tag, ".out_pc_branch"}, 64'(out_pc_branch), 64'(br));
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    set_req(4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    idle();
    repeat (3) tick();
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_dst", 64'(out_dst), 64'd0);
    check("rst.out_reg_dst", 64'(out_reg_dst), 64'd0);
    check("rst.out_wb_wr", 64'(out_wb_wr), 64'd0);
    check("rst.out_pc_branch", 64'(out_pc_branch), 64'd0);
    check("rst.perf_accept", 64'(perf_accept), pexp(0));
    check("rst.perf_stall", 64'(perf_stall), pexp(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op("add", ALU_ADD, S1_SRC1, 32'd5, 32'd7, 32'd0, 1'b1, 5'd3, 1'b0, 32'd12, 1'b1);
    check("perf_accept_1", 64'(perf_accept), pexp(1));
    run_op("sub", ALU_SUB, S1_SRC1, 32'd3, 32'd5, 32'd0, 1'b1, 5'd4, 1'b0, 32'hFFFF_FFFE, 1'b1);
    run_op("sra", ALU_SRA, S1_SRC1, 32'h8000_0000, 32'h24, 32'd0, 1'b1, 5'd5, 1'b0, 32'hF800_0000, 1'b1);
    run_op("srl", ALU_SRL, S1_SRC1, 32'h8000_0000, 32'h24, 32'd0, 1'b1, 5'd5, 1'b0, 32'h0800_0000, 1'b1);
    run_op("sll", ALU_SLL, S1_SRC1, 32'd1, 32'h1F, 32'd0, 1'b1, 5'd6, 1'b0, 32'h8000_0000, 1'b1);
    run_op("sltu", ALU_SLTU, S1_SRC1, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 5'd7, 1'b0, 32'd1, 1'b1);
    run_op("slt", ALU_SLT, S1_SRC1, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 5'd7, 1'b0, 32'd0, 1'b1);
    run_op("eq", ALU_EQ, S1_SRC1, 32'h55, 32'h55, 32'd0, 1'b0, 5'd0, 1'b1, 32'd1, 1'b0);
    run_op("ne", ALU_NE, S1_SRC1, 32'h55, 32'h55, 32'd0, 1'b0, 5'd0, 1'b1, 32'd0, 1'b0);
    run_op("and", ALU_AND, S1_SRC1, 32'hF0F0, 32'hFF00, 32'd0, 1'b1, 5'd8, 1'b0, 32'hF000, 1'b1);
    run_op("or", ALU_OR, S1_SRC1, 32'hF0F0, 32'hFF00, 32'd0, 1'b1, 5'd9, 1'b0, 32'hFFF0, 1'b1);
    run_op("x0", ALU_ADD, S1_SRC1, 32'd1, 32'd2, 32'd0, 1'b1, 5'd0, 1'b0, 32'd3, 1'b0);
    run_op("pc", ALU_ADD, S1_PC, 32'hDEAD, 32'd8, 32'h100, 1'b1, 5'd10, 1'b0, 32'h108, 1'b1);
    run_op("undef", 4'hF, S1_SRC1, 32'd9, 32'd9, 32'd0, 1'b1, 5'd11, 1'b0, 32'd0, 1'b1);

    // Four back-to-back ops, writeback stalled for the first three cycles.
    out_ready = 1'b0;
    set_req(ALU_ADD, S1_SRC1, 32'd10, 32'd1, 32'd0, 1'b1, 5'd1, 1'b0);
    @(negedge clk);
    check("bp.a_ready", 64'(in_ready), 64'd1);
    tick();
    set_req(ALU_ADD, S1_SRC1, 32'd20, 32'd1, 32'd0, 1'b1, 5'd2, 1'b0);
    @(negedge clk);
    check("bp.b_ready", 64'(in_ready), 64'd1);
    tick();
    set_req(ALU_ADD, S1_SRC1, 32'd30, 32'd1, 32'd0, 1'b1, 5'd3, 1'b0);
    @(negedge clk);
    check("bp.c_blocked", 64'(in_ready), 64'd0);
    check("bp.hold_a", 64'(out_dst), 64'd11);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.c_ready", 64'(in_ready), 64'd1);
    check("bp.out_a", 64'(out_dst), 64'd11);
    tick();
    set_req(ALU_ADD, S1_SRC1, 32'd40, 32'd1, 32'd0, 1'b1, 5'd4, 1'b0);
    @(negedge clk);
    check("bp.d_ready", 64'(in_ready), 64'd1);
    check("bp.out_b", 64'(out_dst), 64'd21);
    tick();
    idle();
    @(negedge clk);
    check("bp.out_c", 64'(out_dst), 64'd31);
    check("bp.out_c_dst", 64'(out_reg_dst), 64'd3);
    tick();
    @(negedge clk);
    check("bp.out_d_valid", 64'(out_valid), 64'd1);
    check("bp.out_d", 64'(out_dst), 64'd41);
    tick();
    @(negedge clk);
    check("bp.drained", 64'(out_valid), 64'd0);

    // Output held stable across a two-cycle stall.
    set_req(ALU_XOR, S1_SRC1, 32'hF0F0, 32'h0FF0, 32'd0, 1'b1, 5'd12, 1'b0);
    tick();
    idle();
    out_ready = 1'b0;
    tick();
    @(negedge clk);
    check("hold.v1", 64'(out_valid), 64'd1);
    check("hold.d1", 64'(out_dst), 64'hFF00);
    tick();
    @(negedge clk);
    check("hold.v2", 64'(out_valid), 64'd1);
    check("hold.d2", 64'(out_dst), 64'hFF00);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("hold.v3", 64'(out_valid), 64'd1);
    tick();
    @(negedge clk);
    check("hold.gone", 64'(out_valid), 64'd0);

    // Flush with two ops in flight and a third request waiting.
    out_ready = 1'b0;
    set_req(ALU_ADD, S1_SRC1, 32'd100, 32'd0, 32'd0, 1'b1, 5'd13, 1'b0);
    tick();
    set_req(ALU_ADD, S1_SRC1, 32'd200, 32'd0, 32'd0, 1'b1, 5'd14, 1'b0);
    tick();
    set_req(ALU_ADD, S1_SRC1, 32'd300, 32'd0, 32'd0, 1'b1, 5'd15, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check("flush.in_ready", 64'(in_ready), 64'd0);
    check("flush.out_valid_same", 64'(out_valid), 64'd1);
    tick();
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    @(negedge clk);
    check("flush.out_valid_next", 64'(out_valid), 64'd0);
    check("flush.in_ready_after", 64'(in_ready), 64'd1);
    tick();
    @(negedge clk);
    check("flush.no_ghost1", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    check("flush.no_ghost2", 64'(out_valid), 64'd0);
    check("perf_stall_4", 64'(perf_stall), pexp(4));
    check("perf_accept_sat", 64'(perf_accept), pexp(15));
    tick();

    // Twenty back-to-back accepts at full throughput.
    for (int k = 0; k < 20; k++) begin
      set_req(ALU_ADD, S1_SRC1, 32'(k), 32'd0, 32'd0, 1'b1, 5'd1, 1'b0);
      @(negedge clk);
      check($sformatf("burst%0d.ready", k), 64'(in_ready), 64'd1);
      if (k >= 2) check($sformatf("burst%0d.out", k), 64'(out_dst), 64'(k - 2));
      tick();
    end
    idle();
    @(negedge clk);
    check("burst.out18", 64'(out_dst), 64'd18);
    tick();
    @(negedge clk);
    check("burst.out19", 64'(out_dst), 64'd19);
    tick();
    @(negedge clk);
    check("burst.drained", 64'(out_valid), 64'd0);
    check("burst.perf_accept", 64'(perf_accept), pexp(15));
    check("burst.perf_stall", 64'(perf_stall), pexp(4));
    tick();

    // Asynchronous reset with ops in flight.
    out_ready = 1'b0;
    set_req(ALU_ADD, S1_SRC1, 32'd1, 32'd1, 32'd0, 1'b1, 5'd2, 1'b0);
    tick();
    set_req(ALU_ADD, S1_SRC1, 32'd2, 32'd2, 32'd0, 1'b1, 5'd3, 1'b0);
    tick();
    check("rst2.before", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst2.out_valid", 64'(out_valid), 64'd0);
    check("rst2.out_dst", 64'(out_dst), 64'd0);
    check("rst2.out_reg_dst", 64'(out_reg_dst), 64'd0);
    check("rst2.perf_accept", 64'(perf_accept), pexp(0));
    check("rst2.perf_stall", 64'(perf_stall), pexp(0));
    idle();
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("rst2.after", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
